// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//
// N-channel arbitrating mux with a registered single-entry output stage.
// One of `channels` valid/ready input streams is picked each cycle, either by
// round-robin arbitration or by an explicit channel select in forced mode.
// The winning word is loaded into the output stage. The stage drains and
// reloads on the same edge, so it sustains one word per cycle.
//
// Parameters
//   bits        data width per channel
//   channels    number of input channels (2..16)
//   sel_bits    channel index width, ceil(log2(channels))
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   in_data     packed channel words, channel i at [i*bits +: bits]
//   in_valid    per-channel valid
//   in_ready    per-channel ready, one-hot or zero
//   force_en    1 = use force_sel, 0 = round-robin
//   force_sel   channel granted when force_en = 1
//   out_data    registered selected word
//   out_channel index of the channel that supplied out_data
//   out_valid   output stage holds a word
//   out_ready   consumer accepts the word this cycle
// -----------------------------------------------------------------------------
module rr_arb_mux #(
    parameter int bits     = 16,
    parameter int channels = 16,
    parameter int sel_bits = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [channels*bits-1:0]   in_data,
    input  logic [channels-1:0]        in_valid,
    output logic [channels-1:0]        in_ready,
    input  logic                       force_en,
    input  logic [sel_bits-1:0]        force_sel,
    output logic [bits-1:0]            out_data,
    output logic [sel_bits-1:0]        out_channel,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam logic [sel_bits-1:0] last_idx = sel_bits'(channels - 1);

    // Output stage and round-robin pointer.
    logic [bits-1:0]     out_data_q,    out_data_d;
    logic [sel_bits-1:0] out_channel_q, out_channel_d;
    logic                out_valid_q,   out_valid_d;
    logic [sel_bits-1:0] ptr_q,         ptr_d;

    // Arbitration results.
    logic                hi_found, lo_found;
    logic [sel_bits-1:0] hi_idx,   lo_idx;
    logic                rr_found;
    logic [sel_bits-1:0] rr_idx;
    logic                forced_found;
    logic                grant_valid;
    logic [sel_bits-1:0] grant_idx;
    logic [bits-1:0]     grant_data;
    logic                can_load;
    logic                transfer;

    // -------------------------------------------------------------------------
    // Round-robin search.
    // The scan ptr, ptr+1, ... wraps at channels-1. It is split into two
    // fixed-priority searches: the lowest valid index at or above ptr
    // (hi_*), else the lowest valid index overall (lo_*). Both loops run from
    // the top down, so the lowest matching index is the last one written.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves a latch behind.
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = channels - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = sel_bits'(i);
                if (sel_bits'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = sel_bits'(i);
                end
            end
        end
        rr_found = hi_found | lo_found;
        rr_idx   = hi_found ? hi_idx : lo_idx;
    end

    // -------------------------------------------------------------------------
    // Forced select.
    // Matching force_sel against each real channel also covers the
    // out-of-range case: a select >= channels matches nothing and grants
    // nothing.
    // -------------------------------------------------------------------------
    always_comb begin
        forced_found = 1'b0;
        for (int i = 0; i < channels; i++) begin
            if (force_sel == sel_bits'(i) && in_valid[i]) begin
                forced_found = 1'b1;
            end
        end
    end

    // Grant, capacity and handshake.
    always_comb begin
        grant_valid = force_en ? forced_found : rr_found;
        grant_idx   = force_en ? force_sel    : rr_idx;

        // The stage can take a word when it is empty, or when its current
        // word leaves on this same edge.
        can_load = !out_valid_q || out_ready;

        // A granted channel is always valid, so ready alone makes a transfer.
        // Reset blocks acceptance so that no word is lost in the reset cycle.
        transfer = grant_valid && can_load && !reset;

        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < channels; i++) begin
            if (grant_idx == sel_bits'(i)) begin
                in_ready[i] = transfer;
                grant_data  = in_data[i*bits +: bits];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic for the output stage and the pointer.
    // The pointer only advances on round-robin transfers. A forced transfer
    // leaves the pointer alone, so round-robin order resumes where it stopped.
    // -------------------------------------------------------------------------
    always_comb begin
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        ptr_d         = ptr_q;

        if (transfer) begin
            out_data_d    = grant_data;
            out_channel_d = grant_idx;
            out_valid_d   = 1'b1;
            if (!force_en) begin
                ptr_d = (grant_idx == last_idx) ? '0 : grant_idx + sel_bits'(1);
            end
        end else if (out_ready) begin
            // Drain only: data and channel keep their last values.
            out_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // out_data and out_channel are visible on the ports, so they are cleared
    // too, giving defined values straight out of reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments, so all
        // registers take their new values together at the clock edge.
        if (reset) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            ptr_q         <= '0;
        end else begin
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
            ptr_q         <= ptr_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
//
// Bench for rr_arb_mux. The main instance uses the default 16 x 16-bit
// configuration and runs against a reference model:
//   - The model arbitrates from its own pointer and predicts in_ready.
//   - Each word the model expects to be accepted goes into a scoreboard.
//   - The word is popped when the consumer takes it.
// Directed sequence checks cover reset, fairness, streaming, backpressure and
// forced mode. A small 4 x 8-bit instance covers reset while a word is held.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;

    localparam int W = 16;
    localparam int N = 16;
    localparam int S = 4;

    // Main instance signals.
    logic           clock = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           force_en;
    logic [S-1:0]   force_sel;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_channel;
    logic           out_valid;
    logic           out_ready;

    // Small instance signals.
    logic        s_reset;
    logic [31:0] s_in_data;
    logic [3:0]  s_in_valid;
    logic [3:0]  s_in_ready;
    logic        s_force_en;
    logic [1:0]  s_force_sel;
    logic [7:0]  s_out_data;
    logic [1:0]  s_out_channel;
    logic        s_out_valid;
    logic        s_out_ready;

    always #5 clock = ~clock;

    rr_arb_mux #(.bits(W), .channels(N), .sel_bits(S)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .force_en    (force_en),
        .force_sel   (force_sel),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    rr_arb_mux #(.bits(8), .channels(4), .sel_bits(2)) u_small (
        .clock       (clock),
        .reset       (s_reset),
        .in_data     (s_in_data),
        .in_valid    (s_in_valid),
        .in_ready    (s_in_ready),
        .force_en    (s_force_en),
        .force_sel   (s_force_sel),
        .out_data    (s_out_data),
        .out_channel (s_out_channel),
        .out_valid   (s_out_valid),
        .out_ready   (s_out_ready)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic [S-1:0] ch;
    } word_t;

    typedef struct {
        logic [W-1:0] d;
        logic [S-1:0] ch;
        int           cyc;
    } seen_t;

    word_t sb[$];     // words the model expects in the output stage
    seen_t seen[$];   // words observed leaving the output stage

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    // Reference model state.
    int         m_ptr   = 0;
    bit         m_valid = 1'b0;
    logic [N-1:0] exp_rdy;
    bit         m_can;
    bit         m_found;
    int         m_g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference arbitration: literal scan from ptr with wrap-around, or the
    // forced channel if it is valid.
    function automatic void pick(input logic [N-1:0] v, input int ptr, input logic fe,
                                 input logic [S-1:0] fs, output bit found, output int g);
        int idx;
        found = 1'b0;
        g     = 0;
        if (fe) begin
            if (v[fs]) begin
                found = 1'b1;
                g     = int'(fs);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (!found && v[idx[S-1:0]]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [W-1:0] v);
        in_data[ch*W +: W] = v;
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor and scoreboard, evaluated mid-cycle while inputs are stable.
    initial forever begin
        @(negedge clock);
        if (mon_en) begin
            m_can = !m_valid || out_ready;
            pick(in_valid, m_ptr, force_en, force_sel, m_found, m_g);
            exp_rdy = '0;
            if (!reset && m_can && m_found) exp_rdy[m_g[S-1:0]] = 1'b1;
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid && sb.size() > 0) begin
                check("out_data", 64'(out_data), 64'(sb[0].d));
                check("out_channel", 64'(out_channel), 64'(sb[0].ch));
            end
            // Advance the model to the coming clock edge.
            if (reset) begin
                sb.delete();
                m_valid = 1'b0;
                m_ptr   = 0;
            end else begin
                if (m_valid && out_ready) begin
                    seen.push_back('{out_data, out_channel, cyc});
                    if (sb.size() > 0) void'(sb.pop_front());
                    m_valid = 1'b0;
                end
                if (exp_rdy != '0) begin
                    sb.push_back('{in_data[m_g*W +: W], m_g[S-1:0]});
                    m_valid = 1'b1;
                    if (!force_en) m_ptr = (m_g + 1) % N;
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        force_en  = 1'b0;
        force_sel = '0;
        in_data   = '0;
        for (int ch = 0; ch < N; ch++) set_word(ch, 16'(16'hA000 + ch));

        s_reset     = 1'b1;
        s_in_valid  = '0;
        s_out_ready = 1'b1;
        s_force_en  = 1'b0;
        s_force_sel = '0;
        s_in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset for two cycles with every channel requesting.
        tick();
        mon_en = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_channel", 64'(out_channel), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd0);
        reset   = 1'b0;
        s_reset = 1'b0;
        #1;
        check("first_grant", 64'(in_ready), 64'h0001);

        // Fairness with all channels valid: 0..15, 0, 1.
        seen.delete();
        repeat (18) tick();
        in_valid = '0;
        tick();
        check("fair_count", 64'(seen.size()), 64'd18);
        for (int i = 0; i < 18 && i < seen.size(); i++) begin
            check("fair_ch", 64'(seen[i].ch), 64'(i % 16));
            check("fair_data", 64'(seen[i].d), 64'(16'hA000 + (i % 16)));
        end

        // Only channels 3 and 9 valid: alternates 3, 9, 3, 9.
        seen.delete();
        in_valid = 16'h0208;
        repeat (4) tick();
        in_valid = '0;
        tick();
        check("alt_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            check("alt_ch", 64'(seen[i].ch), (i % 2 == 0) ? 64'd3 : 64'd9);
        end

        // Channel 5 streams five words back to back.
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            set_word(5, 16'(16'h1111 + i));
            in_valid = 16'h0020;
            tick();
        end
        in_valid = '0;
        tick();
        check("stream_count", 64'(seen.size()), 64'd5);
        for (int i = 0; i < 5 && i < seen.size(); i++) begin
            check("stream_data", 64'(seen[i].d), 64'(16'h1111 + i));
            check("stream_ch", 64'(seen[i].ch), 64'd5);
            check("stream_gap", 64'(seen[i].cyc - seen[0].cyc), 64'(i));
        end

        // Backpressure: 0xBEEF is held, then drains as channel 2 loads.
        set_word(0, 16'hBEEF);
        in_valid  = 16'h0001;
        out_ready = 1'b0;
        #1;
        check("bp_load_rdy", 64'(in_ready), 64'h0001);
        tick();
        set_word(2, 16'h2222);
        in_valid = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_hold_data", 64'(out_data), 64'hBEEF);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_rdy", 64'(in_ready), 64'd0);
            tick();
        end
        seen.delete();
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(in_ready), 64'h0004);
        tick();
        check("bp_new_data", 64'(out_data), 64'h2222);
        check("bp_new_ch", 64'(out_channel), 64'd2);
        check("bp_new_valid", 64'(out_valid), 64'd1);
        check("bp_drained", (seen.size() > 0) ? 64'(seen[0].d) : 64'd0, 64'hBEEF);
        in_valid = '0;
        tick();

        // Forced mode: only channel 7, pointer left at 3.
        force_en  = 1'b1;
        force_sel = 4'd7;
        in_valid  = '1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("force_rdy", 64'(in_ready), 64'h0080);
            tick();
        end
        in_valid = 16'hFF7F;
        #1;
        check("force_norq_rdy", 64'(in_ready), 64'd0);
        tick();
        check("force_drained", 64'(out_valid), 64'd0);
        force_en = 1'b0;
        in_valid = '1;
        #1;
        check("force_ptr_kept", 64'(in_ready), 64'h0008);
        tick();
        in_valid = '0;
        tick();

        // Small instance: reset while a word is held under backpressure.
        s_in_valid = 4'b0010;
        #1;
        check("s_grant1", 64'(s_in_ready), 64'h2);
        tick();
        s_in_valid  = '0;
        s_out_ready = 1'b0;
        tick();
        check("s_held_valid", 64'(s_out_valid), 64'd1);
        check("s_held_data", 64'(s_out_data), 64'hA1);
        check("s_held_ch", 64'(s_out_channel), 64'd1);
        s_reset    = 1'b1;
        s_in_valid = 4'b1111;
        #1;
        check("s_rst_rdy", 64'(s_in_ready), 64'd0);
        tick();
        check("s_rst_valid", 64'(s_out_valid), 64'd0);
        check("s_rst_data", 64'(s_out_data), 64'd0);
        check("s_rst_ch", 64'(s_out_channel), 64'd0);
        s_reset     = 1'b0;
        s_out_ready = 1'b1;
        #1;
        check("s_after_rdy", 64'(s_in_ready), 64'h1);
        tick();
        check("s_after_ch", 64'(s_out_channel), 64'd0);
        check("s_after_data", 64'(s_out_data), 64'hA0);
        check("s_after_valid", 64'(s_out_valid), 64'd1);
        s_in_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
